hex_display_ctrl: RTL and testbench
===================================

// Module: hex_display_ctrl
// PURPOSE
//   Sequences a bank of NUM_DIGITS seven-segment decoders (4-bit nibble + per-digit 'off' blank).
//   Latches a display value via a load handshake, applies leading-zero suppression,
//   a right-to-left "reveal" animation, blinking and global blanking.
//   Sits between the project datapath/top level and the per-digit SevenSeg instances.
//   Digit 0 is the rightmost, least-significant nibble.
// PARAMETERS
//   NUM_DIGITS  6           number of digits driven (1..8)
//   STEP_DIV    5_000_000   clk cycles per reveal step
//   BLINK_DIV   25_000_000  clk cycles per blink half-period
// PORTS
//   clk        in   1             system clock, rising edge
//   reset_n    in   1             asynchronous, active-low reset
//   load       in   1             request to capture value; accepted when busy=0
//   value      in   4*NUM_DIGITS  hex value to display
//   reveal_en  in   1             sampled with load: 1 = animate reveal, 0 = show at once
//   lz_en      in   1             1 = blank leading zero digits (live, not latched)
//   blink_en   in   1             1 = blink the display while in SHOW
//   blank_all  in   1             1 = force every digit off (combinational override)
//   clear      in   1             synchronous return to IDLE (display dark)
//   digits     out  4*NUM_DIGITS  nibble per digit; [3:0] = digit 0
//   off        out  NUM_DIGITS    per-digit blank; 1 = dark; [0] = digit 0
//   busy       out  1             1 while REVEAL in progress; load ignored
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, value reg=0, revealed=0, step_cnt=0, blink_cnt=0,
//     blink_phase=0 -> digits=0, off=all 1s, busy=0. Reset mid-REVEAL aborts immediately.
//   States: IDLE (all dark), REVEAL, SHOW. busy = (state==REVEAL).
//   Accept: edge where load=1 & busy=0 & clear=0. Captures value; revealed<=1 and
//     state<=REVEAL if reveal_en, else revealed<=NUM_DIGITS and state<=SHOW. Accept allowed
//     in IDLE and SHOW (reload restarts). load while busy=1: dropped, no state change.
//   clear=1: state<=IDLE, revealed<=0, counters<=0; value reg retained; clear beats load.
//   REVEAL: step_cnt counts 0..STEP_DIV-1; on wrap revealed<=revealed+1. The wrap that makes
//     revealed==NUM_DIGITS also moves state to SHOW. Total REVEAL time (NUM_DIGITS-1)*STEP_DIV.
//   Blink: blink_cnt and blink_phase held at 0 unless state==SHOW & blink_en=1; then
//     blink_cnt counts 0..BLINK_DIV-1, toggles blink_phase on wrap (phase 1 = dark,
//     first toggle BLINK_DIV cycles after enabling). Dropping blink_en: phase 0 next edge.
//   Leading zero (lz_en=1): digit i>0 blanked if nibbles i..NUM_DIGITS-1 all zero.
//     Digit 0 never lz-blanked (value 0 shows single "0").
//   off[i] = blank_all | (state==IDLE) | (i >= revealed) | lz(i) | blink_phase.
//   digits = captured value register, driven directly (valid after capture edge).
//   No combinational input->output path except blank_all, lz_en -> off.
//   Latency: accept edge -> digits/off/busy updated right after that same edge.
//   Counters sized $clog2 of divisors; no overflow: all wrap at DIV-1 exactly.
// TESTING  (NUM_DIGITS=6, STEP_DIV=4, BLINK_DIV=3)
//   Reset asserted -> off=6'b111111, digits=24'h0, busy=0; held during clk toggling.
//   load value=24'h000A3F, reveal_en=0, lz_en=1 -> after edge digits=24'h000A3F, off=6'b111000, busy=0.
//   load 24'h123456 reveal_en=1 -> busy=1, off=6'b111110; each 4 cycles one more digit lit;
//     after 20 cycles off=6'b000000, busy=0; load 24'hFFFFFF mid-reveal ignored (digits unchanged).
//   SHOW, blink_en=1 -> off=000000 for 3 cycles, 111111 for 3, repeating; blink_en=0 -> 000000 next edge.
//   load 24'h0, lz_en=1 -> off=6'b111110, digits=0; toggle lz_en=0 -> off=6'b000000; blank_all=1 -> 111111.
//   clear=1 & load=1 same edge -> IDLE, off=111111, value unchanged; reset_n low mid-REVEAL -> all dark at once.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
//   Sequencer for a bank of NUM_DIGITS seven-segment decoders. It captures a hex
//   value through a load handshake. It can reveal the value one digit at a time,
//   from right to left. It can also blank leading zeros, blink the whole display,
//   or force every digit dark. Digit 0 is the rightmost, least-significant nibble.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   load       in   capture request, accepted when busy=0 and clear=0
//   value      in   hex value to display, 4 bits per digit
//   reveal_en  in   sampled with load: 1 = animate the reveal, 0 = show at once
//   lz_en      in   blank leading zero digits (live)
//   blink_en   in   blink the display while showing
//   blank_all  in   force all digits off (combinational)
//   clear      in   synchronous return to IDLE; has priority over load
//   digits     out  captured nibbles, [3:0] = digit 0
//   off        out  per-digit blank, 1 = dark, [0] = digit 0
//   busy       out  high while the reveal animation runs
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int STEP_DIV   = 5_000_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    reveal_en,
  input  logic                    lz_en,
  input  logic                    blink_en,
  input  logic                    blank_all,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   off,
  output logic                    busy
);

  localparam int STEP_W  = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int REV_W   = $clog2(NUM_DIGITS + 1);

  localparam logic [STEP_W-1:0]  STEP_MAX  = STEP_W'(STEP_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
  localparam logic [REV_W-1:0]   REV_ONE   = REV_W'(1);
  localparam logic [REV_W-1:0]   REV_FULL  = REV_W'(NUM_DIGITS);
  localparam logic [REV_W-1:0]   REV_LAST  = REV_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REVEAL = 2'd1,
    S_SHOW   = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [4*NUM_DIGITS-1:0]   r_value;
  logic [REV_W-1:0]          r_revealed;
  logic [STEP_W-1:0]         r_step_cnt;
  logic [BLINK_W-1:0]        r_blink_cnt;
  logic                      r_blink_phase;

  logic                      w_accept;
  logic                      w_step_wrap;
  logic                      w_blink_run;
  logic                      w_zero_run;
  logic [NUM_DIGITS-1:0]     w_off;
  logic                      w_busy;

  // A load is honoured only when no reveal is running and clear is low.
  assign w_accept    = load & (r_state != S_REVEAL) & ~clear;
  assign w_step_wrap = (r_step_cnt == STEP_MAX);
  assign w_blink_run = (r_state == S_SHOW) & blink_en;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state. With a single digit, the reveal has nothing to animate.
  always_comb begin
    w_state_nxt = r_state;
    if (clear)
      w_state_nxt = S_IDLE;
    else if (w_accept)
      w_state_nxt = (reveal_en && (NUM_DIGITS > 1)) ? S_REVEAL : S_SHOW;
    else if ((r_state == S_REVEAL) && w_step_wrap && (r_revealed == REV_LAST))
      w_state_nxt = S_SHOW;
  end

  // Captured value, reveal progress and blink timing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value       <= '0;
      r_revealed    <= '0;
      r_step_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (w_accept)
        r_value <= value;

      if (clear) begin
        r_revealed <= '0;
        r_step_cnt <= '0;
      end else if (w_accept) begin
        r_revealed <= reveal_en ? REV_ONE : REV_FULL;
        r_step_cnt <= '0;
      end else if (r_state == S_REVEAL) begin
        if (w_step_wrap) begin
          r_step_cnt <= '0;
          r_revealed <= r_revealed + REV_ONE;
        end else begin
          r_step_cnt <= r_step_cnt + STEP_W'(1);
        end
      end

      // A reload restarts the blink cycle from its lit phase.
      if (clear || w_accept || !w_blink_run) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == BLINK_MAX) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // FSM outputs. w_zero_run tracks whether every nibble from the top down to
  // digit i is zero. Digit 0 is exempt, so a zero value still shows "0".
  always_comb begin
    w_busy     = (r_state == S_REVEAL);
    w_zero_run = 1'b1;
    w_off      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_value[4*i +: 4] == 4'h0);
      w_off[i]   = blank_all
                 | (r_state == S_IDLE)
                 | (i >= int'(r_revealed))
                 | (lz_en & w_zero_run & (i != 0))
                 | r_blink_phase;
    end
  end

  assign digits = r_value;
  assign off    = w_off;
  assign busy   = w_busy;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load;
  logic [23:0]   value;
  logic          reveal_en;
  logic          lz_en;
  logic          blink_en;
  logic          blank_all;
  logic          clear;
  logic [23:0]   digits;
  logic [5:0]    off;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0] d;
    logic [5:0]  o;
    logic        b;
  } exp_t;

  exp_t q[$];

  hex_display_ctrl #(.NUM_DIGITS(ND), .STEP_DIV(4), .BLINK_DIV(3)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value),
    .reveal_en(reveal_en), .lz_en(lz_en), .blink_en(blink_en),
    .blank_all(blank_all), .clear(clear),
    .digits(digits), .off(off), .busy(busy)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] d, input logic [5:0] o, input logic b);
    exp_t e;
    e.d = d; e.o = o; e.b = b;
    q.push_back(e);
  endtask

  task automatic chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    checks++;
    assert (digits === e.d) else begin
      errors++;
      $error("FAIL %s digits got %h expected %h", tag, digits, e.d);
    end
    checks++;
    assert (off === e.o) else begin
      errors++;
      $error("FAIL %s off got %b expected %b", tag, off, e.o);
    end
    checks++;
    assert (busy === e.b) else begin
      errors++;
      $error("FAIL %s busy got %b expected %b", tag, busy, e.b);
    end
  endtask

  initial begin
    int rev;
    int phase;
    logic [5:0] exp_off;

    reset_n = 1'b0; load = 1'b0; value = '0; reveal_en = 1'b0; lz_en = 1'b0;
    blink_en = 1'b0; blank_all = 1'b0; clear = 1'b0;

    // Reset held while the clock runs
    for (int k = 0; k < 3; k++) begin
      step();
      push(24'h0, 6'b111111, 1'b0);
      chk("reset");
    end
    reset_n = 1'b1;
    step();
    push(24'h0, 6'b111111, 1'b0);
    chk("idle_after_reset");

    // Immediate show with leading-zero suppression
    load = 1'b1; value = 24'h000A3F; reveal_en = 1'b0; lz_en = 1'b1;
    step();
    load = 1'b0;
    push(24'h000A3F, 6'b111000, 1'b0);
    chk("load_lz");

    // Reveal animation; a load midway through is dropped
    load = 1'b1; value = 24'h123456; reveal_en = 1'b1;
    step();
    load = 1'b0;
    push(24'h123456, 6'b111110, 1'b1);
    chk("reveal_start");
    for (int s = 1; s <= 20; s++) begin
      if (s == 10) begin
        load = 1'b1; value = 24'hFFFFFF;
      end else begin
        load = 1'b0;
      end
      step();
      rev     = 1 + s / 4;
      exp_off = 6'b111111 << rev;
      push(24'h123456, exp_off, (rev < ND) ? 1'b1 : 1'b0);
      chk($sformatf("reveal_s%0d", s));
    end
    load = 1'b0;

    // Blinking in SHOW: three cycles lit, three dark
    blink_en = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      step();
      phase = (s / 3) % 2;
      push(24'h123456, (phase == 1) ? 6'b111111 : 6'b000000, 1'b0);
      chk($sformatf("blink_s%0d", s));
    end
    blink_en = 1'b0;
    step();
    push(24'h123456, 6'b000000, 1'b0);
    chk("blink_off");

    // Zero value: digit 0 stays lit; lz_en and blank_all act combinationally
    load = 1'b1; value = 24'h000000; reveal_en = 1'b0; lz_en = 1'b1;
    step();
    load = 1'b0;
    push(24'h000000, 6'b111110, 1'b0);
    chk("zero_lz");
    lz_en = 1'b0;
    #1;
    push(24'h000000, 6'b000000, 1'b0);
    chk("zero_nolz");
    blank_all = 1'b1;
    #1;
    push(24'h000000, 6'b111111, 1'b0);
    chk("blank_all");
    blank_all = 1'b0;

    // A clear arriving with a load wins; the value register is kept
    load = 1'b1; value = 24'h654321; reveal_en = 1'b0;
    step();
    load = 1'b0;
    push(24'h654321, 6'b000000, 1'b0);
    chk("reload_show");
    load = 1'b1; clear = 1'b1; value = 24'hABCDEF;
    step();
    load = 1'b0; clear = 1'b0;
    push(24'h654321, 6'b111111, 1'b0);
    chk("clear_beats_load");

    // Asynchronous reset in the middle of a reveal
    load = 1'b1; value = 24'h123456; reveal_en = 1'b1;
    step();
    load = 1'b0;
    push(24'h123456, 6'b111110, 1'b1);
    chk("reveal_again");
    step();
    step();
    reset_n = 1'b0;
    #1;
    push(24'h000000, 6'b111111, 1'b0);
    chk("async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
